// File: rtl/logic_gate_mode_detector_if.sv
// logic_gate_mode_detector_if: sample stream in, candidate/verdict status out
interface logic_gate_mode_detector_if;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] y;
   logic [7:0] cand_mask;
   logic       done;
   logic       fail;
   logic       ambiguous;
   logic [2:0] mode_found;
   logic [7:0] sample_cnt;
   modport master (
      output start, in_valid, a, b, y,
      input  in_ready, cand_mask, done, fail, ambiguous, mode_found, sample_cnt
   );
   modport slave (
      input  start, in_valid, a, b, y,
      output in_ready, cand_mask, done, fail, ambiguous, mode_found, sample_cnt
   );
endinterface

// File: rtl/logic_gate_mode_detector.sv
// logic_gate_mode_detector: narrows 8 gate hypotheses against observed (a,b,y) samples
module logic_gate_mode_detector #(
   parameter int MAX_SAMPLES = 16
) (
   input logic                         clk,
   input logic                         rst,
   logic_gate_mode_detector_if.slave   bus
);
   typedef enum logic [2:0] {IDLE, SEARCH, LOCKED, FAIL, AMBIG} state_t;
   state_t     state_q;
   logic [7:0] cand_mask_q;
   logic       done_q;
   logic       fail_q;
   logic       ambiguous_q;
   logic [2:0] mode_found_q;
   logic [7:0] sample_cnt_q;
   logic [7:0] match;
   logic [7:0] cand_mask_d;
   logic [7:0] sample_cnt_d;
   logic [3:0] pop;
   logic [2:0] low;
   assign bus.in_ready   = (state_q == SEARCH) && !bus.start;
   assign bus.cand_mask  = cand_mask_q;
   assign bus.done       = done_q;
   assign bus.fail       = fail_q;
   assign bus.ambiguous  = ambiguous_q;
   assign bus.mode_found = mode_found_q;
   assign bus.sample_cnt = sample_cnt_q;
   // surviving candidates after this sample, their count and the lowest survivor
   always_comb begin
      match = {bus.b == bus.y,
               ~(bus.a ^ bus.b) == bus.y,
               (bus.a ^ bus.b) == bus.y,
               ~(bus.a | bus.b) == bus.y,
               ~(bus.a & bus.b) == bus.y,
               ~bus.a == bus.y,
               (bus.a | bus.b) == bus.y,
               (bus.a & bus.b) == bus.y};
      cand_mask_d  = cand_mask_q & match;
      sample_cnt_d = sample_cnt_q + 8'd1;
      pop = '0;
      low = '0;
      for (int i = 7; i >= 0; i--) begin
         pop = pop + {3'b0, cand_mask_d[i]};
         low = cand_mask_d[i] ? 3'(i) : low;
      end
   end
   // FSM with registered verdict outputs; start pre-empts any sample offered the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cand_mask_q  <= 8'hFF;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         ambiguous_q  <= 1'b0;
         mode_found_q <= 3'd0;
         sample_cnt_q <= 8'd0;
      end else if (bus.start) begin
         state_q      <= SEARCH;
         cand_mask_q  <= 8'hFF;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         ambiguous_q  <= 1'b0;
         mode_found_q <= 3'd0;
         sample_cnt_q <= 8'd0;
      end else if (state_q == SEARCH && bus.in_valid) begin
         cand_mask_q  <= cand_mask_d;
         sample_cnt_q <= sample_cnt_d;
         if (pop == 4'd1) begin
            state_q      <= LOCKED;
            done_q       <= 1'b1;
            mode_found_q <= low;
         end else if (cand_mask_d == 8'h00) begin
            state_q      <= FAIL;
            done_q       <= 1'b1;
            fail_q       <= 1'b1;
            mode_found_q <= 3'd0;
         end else if (sample_cnt_d == 8'(MAX_SAMPLES)) begin
            state_q      <= AMBIG;
            done_q       <= 1'b1;
            ambiguous_q  <= 1'b1;
            mode_found_q <= low;
         end
      end
   end
endmodule

// File: tb/tb_logic_gate_mode_detector.sv
// tb_logic_gate_mode_detector: directed vectors, expectations queued and checked by a separate monitor
module tb_logic_gate_mode_detector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   typedef struct {
      string       nm;
      int          at;
      bit          sel;
      logic [22:0] v;
   } exp_t;
   exp_t q[$];
   logic_gate_mode_detector_if i0 ();
   logic_gate_mode_detector_if i1 ();
   logic_gate_mode_detector #(.MAX_SAMPLES(16)) u0 (.clk(clk), .rst(rst), .bus(i0));
   logic_gate_mode_detector #(.MAX_SAMPLES(2))  u1 (.clk(clk), .rst(rst), .bus(i1));
   always #5 clk = ~clk;
   // cycle index used to time-stamp expectations
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [22:0] pk(input logic ir, input logic [7:0] m, input logic d, f, am,
                                      input logic [2:0] md, input logic [7:0] c);
      return {ir, m, d, f, am, md, c};
   endfunction
   // monitor: compares every due expectation against the selected DUT
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].at <= cyc) begin
         exp_t e;
         logic [22:0] act;
         e = q.pop_front();
         act = e.sel ? {i1.in_ready, i1.cand_mask, i1.done, i1.fail, i1.ambiguous, i1.mode_found, i1.sample_cnt}
                     : {i0.in_ready, i0.cand_mask, i0.done, i0.fail, i0.ambiguous, i0.mode_found, i0.sample_cnt};
         n_tests++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got {rdy,mask,done,fail,amb,mode,cnt}=%b_%h_%b%b%b_%0d_%0d want %b_%h_%b%b%b_%0d_%0d",
                     e.nm, act[22], act[21:14], act[13], act[12], act[11], act[10:8], act[7:0],
                     e.v[22], e.v[21:14], e.v[13], e.v[12], e.v[11], e.v[10:8], e.v[7:0]);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drv0(input logic s, v, input logic [3:0] aa, bb, yy);
      i0.start = s; i0.in_valid = v; i0.a = aa; i0.b = bb; i0.y = yy;
   endtask
   task automatic drv1(input logic s, v, input logic [3:0] aa, bb, yy);
      i1.start = s; i1.in_valid = v; i1.a = aa; i1.b = bb; i1.y = yy;
   endtask
   task automatic chk(input string nm, input bit sel, input logic [22:0] v);
      exp_t e;
      e.nm = nm; e.at = cyc; e.sel = sel; e.v = v;
      q.push_back(e);
   endtask
   initial begin
      drv0(0, 0, 0, 0, 0);
      drv1(0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      drv0(0, 1, 9, 8, 0);
      chk("reset", 0, pk(0, 8'hFF, 0, 0, 0, 0, 0));
      tick(); chk("idle_ignore", 0, pk(0, 8'hFF, 0, 0, 0, 0, 0));
      drv0(1, 0, 0, 0, 0);
      chk("idle_start_cycle", 0, pk(0, 8'hFF, 0, 0, 0, 0, 0));
      tick(); drv0(0, 1, 9, 8, 8);   chk("search_entry", 0, pk(1, 8'hFF, 0, 0, 0, 0, 0));
      tick(); drv0(0, 0, 0, 0, 0);   chk("and_s1", 0, pk(1, 8'h81, 0, 0, 0, 0, 1));
      tick(); drv0(0, 1, 12, 10, 8); chk("hold_no_valid", 0, pk(1, 8'h81, 0, 0, 0, 0, 1));
      tick(); drv0(0, 1, 0, 0, 0);   chk("lock_and", 0, pk(0, 8'h01, 1, 0, 0, 0, 2));
      tick();                        chk("locked_hold", 0, pk(0, 8'h01, 1, 0, 0, 0, 2));
      drv0(1, 0, 0, 0, 0);
      tick(); drv0(0, 1, 9, 8, 0);   chk("fail_entry", 0, pk(1, 8'hFF, 0, 0, 0, 0, 0));
      tick(); drv0(0, 0, 0, 0, 0);   chk("fail", 0, pk(0, 8'h00, 1, 1, 0, 0, 1));
      drv0(1, 0, 0, 0, 0);
      tick(); drv0(0, 1, 9, 8, 8);
      tick(); drv0(1, 0, 0, 0, 0);   chk("restart_pre", 0, pk(0, 8'h81, 0, 0, 0, 0, 1));
      tick(); drv0(0, 1, 9, 8, 8);   chk("restart", 0, pk(1, 8'hFF, 0, 0, 0, 0, 0));
      tick(); drv0(1, 1, 9, 8, 0);   chk("collide_ready", 0, pk(0, 8'h81, 0, 0, 0, 0, 1));
      tick(); drv0(0, 1, 3, 5, 6);   chk("collide", 0, pk(1, 8'hFF, 0, 0, 0, 0, 0));
      tick(); drv0(0, 0, 0, 0, 0);   chk("lock_xor", 0, pk(0, 8'h20, 1, 0, 0, 5, 1));
      drv0(1, 0, 0, 0, 0);
      tick(); drv0(0, 1, 5, 5, 10);
      tick(); drv0(0, 1, 5, 0, 10);  chk("not_s1", 0, pk(1, 8'h1C, 0, 0, 0, 0, 1));
      tick(); drv0(0, 1, 5, 15, 10); chk("not_s2", 0, pk(1, 8'h14, 0, 0, 0, 0, 2));
      tick(); drv0(0, 0, 0, 0, 0);   chk("lock_not", 0, pk(0, 8'h04, 1, 0, 0, 2, 3));
      drv0(1, 0, 0, 0, 0);
      tick(); drv0(0, 1, 9, 8, 8);
      tick(); rst = 1'b1; drv0(1, 1, 9, 8, 8); chk("rst_pre", 0, pk(0, 8'h81, 0, 0, 0, 0, 1));
      tick(); rst = 1'b0; drv0(0, 1, 9, 8, 8); chk("rst_mid", 0, pk(0, 8'hFF, 0, 0, 0, 0, 0));
      tick();                        chk("rst_idle_hold", 0, pk(0, 8'hFF, 0, 0, 0, 0, 0));
      drv0(0, 0, 0, 0, 0);
      drv1(1, 0, 0, 0, 0);
      tick(); drv1(0, 1, 0, 0, 0);   chk("amb_entry", 1, pk(1, 8'hFF, 0, 0, 0, 0, 0));
      tick();                        chk("amb_s1", 1, pk(1, 8'hA3, 0, 0, 0, 0, 1));
      tick(); drv1(0, 0, 0, 0, 0);   chk("ambiguous", 1, pk(0, 8'hA3, 1, 0, 1, 0, 2));
      tick();                        chk("amb_hold", 1, pk(0, 8'hA3, 1, 0, 1, 0, 2));
      drv1(1, 0, 0, 0, 0);
      tick(); drv1(0, 1, 9, 8, 8);
      tick(); drv1(0, 1, 12, 10, 8); chk("max_s1", 1, pk(1, 8'h81, 0, 0, 0, 0, 1));
      tick(); drv1(0, 0, 0, 0, 0);   chk("max_lock", 1, pk(0, 8'h01, 1, 0, 0, 0, 2));
      for (int k = 0; k < 10 && q.size() > 0; k++) tick();
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
